uart_rx_fsm: RTL and testbench

UART receive controller, the receive-side counterpart of the UART TX FSM on the same serial link. It oversamples rx_in at PRESCALE clocks per bit and detects the start bit. It deserializes DATA_WIDTH bits LSB-first, optionally checks a parity bit, then checks the stop bit. Each good frame is presented as a parallel word with a one-cycle valid strobe, and each bad frame raises an error strobe.

---
 rtl/uart_rx_pkg.sv | 28 ++
 rtl/uart_rx_sampler.sv | 80 ++++++++
 rtl/uart_rx_fsm.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_fsm.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_pkg
//  Description : Shared types and helpers for the UART receive controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    // Receive FSM states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Parity type selector values
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // 2-of-3 majority vote used to reject single-sample line glitches
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sampler
//  Description : Input synchronizer, bit-period edge counter and 3-sample
//                majority voter for the UART receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE = 8,
    parameter int EDGE_W   = $clog2(PRESCALE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    input  logic              cnt_en,
    output logic              rx_s,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic              sampled_bit,
    output logic              sample_done
);

    localparam logic [EDGE_W-1:0] c_edge_last = EDGE_W'(PRESCALE - 1);
    localparam logic [EDGE_W-1:0] c_samp0     = EDGE_W'(PRESCALE / 2 - 1);
    localparam logic [EDGE_W-1:0] c_samp1     = EDGE_W'(PRESCALE / 2);
    localparam logic [EDGE_W-1:0] c_samp2     = EDGE_W'(PRESCALE / 2 + 1);

    logic              r_sync1;
    logic              r_sync2;
    logic [EDGE_W-1:0] r_edge_cnt;
    logic              r_samp0;
    logic              r_samp1;

    // Two-flop synchronizer; reset to the idle level so reset never mimics a start bit
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_sync2 <= r_sync1;
        end
    end

    // Bit-period counter: runs 0..PRESCALE-1 while enabled, held at 0 otherwise
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_edge_cnt <= '0;
        end else if (!cnt_en) begin
            r_edge_cnt <= '0;
        end else if (r_edge_cnt == c_edge_last) begin
            r_edge_cnt <= '0;
        end else begin
            r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
        end
    end

    // First two vote samples; the third is the live synchronized level at the last sample edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_samp0 <= 1'b1;
            r_samp1 <= 1'b1;
        end else begin
            if (r_edge_cnt == c_samp0) begin
                r_samp0 <= r_sync2;
            end
            if (r_edge_cnt == c_samp1) begin
                r_samp1 <= r_sync2;
            end
        end
    end

    assign rx_s        = r_sync2;
    assign edge_cnt    = r_edge_cnt;
    assign sample_done = (r_edge_cnt == c_samp2);
    assign sampled_bit = majority3(r_samp0, r_samp1, r_sync2);

endmodule
`default_nettype wire

// File: rtl/uart_rx_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fsm
//  Description : UART receive controller. Detects the start bit, deserializes
//                DATA_WIDTH bits LSB-first, optionally checks parity, checks
//                the stop bit and reports each frame with a one-cycle strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int EDGE_W = $clog2(PRESCALE);
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [EDGE_W-1:0] c_edge_last = EDGE_W'(PRESCALE - 1);
    localparam logic [BIT_W-1:0]  c_bit_last  = BIT_W'(DATA_WIDTH - 1);

    rx_state_t             r_state;
    rx_state_t             w_next_state;

    logic                  w_cnt_en;
    logic                  w_rx_s;
    logic [EDGE_W-1:0]     w_edge_cnt;
    logic                  w_sampled_bit;
    logic                  w_sample_done;
    logic                  w_edge_last;
    logic                  w_frame_done;
    logic                  w_par_exp;

    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_bad;

    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_data_valid;
    logic                  r_par_err;
    logic                  r_stp_err;
    logic                  r_busy;

    uart_rx_sampler #(
        .PRESCALE (PRESCALE),
        .EDGE_W   (EDGE_W)
    ) u_sampler (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .cnt_en      (w_cnt_en),
        .rx_s        (w_rx_s),
        .edge_cnt    (w_edge_cnt),
        .sampled_bit (w_sampled_bit),
        .sample_done (w_sample_done)
    );

    assign w_edge_last = (w_edge_cnt == c_edge_last);
    assign w_par_exp   = (r_par_typ == PAR_EVEN) ? (^r_shift) : ~(^r_shift);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; the edge counter only runs while staying inside a frame
    always_comb begin
        w_next_state = r_state;
        w_cnt_en     = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_next_state = START;
                end
            end
            START: begin
                w_cnt_en = 1'b1;
                if (w_sample_done && w_sampled_bit) begin
                    // Start bit did not survive the vote: treat as a line glitch
                    w_next_state = IDLE;
                    w_cnt_en     = 1'b0;
                end else if (w_edge_last) begin
                    w_next_state = DATA;
                end
            end
            DATA: begin
                w_cnt_en = 1'b1;
                if (w_edge_last && (r_bit_cnt == c_bit_last)) begin
                    w_next_state = r_par_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                w_cnt_en = 1'b1;
                if (w_edge_last) begin
                    w_next_state = STOP;
                end
            end
            STOP: begin
                w_cnt_en = 1'b1;
                if (w_sample_done) begin
                    // Leave mid stop bit so a back-to-back start edge is not missed
                    w_next_state = IDLE;
                    w_cnt_en     = 1'b0;
                    w_frame_done = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Frame datapath: config latch, bit counter, shift register and parity check
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_par_bad <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_par_en  <= par_en;
                        r_par_typ <= par_typ;
                        r_par_bad <= 1'b0;
                        r_bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (w_sample_done) begin
                        r_shift <= {w_sampled_bit, r_shift[DATA_WIDTH-1:1]};
                    end
                    if (w_edge_last) begin
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                    end
                end
                PARITY: begin
                    if (w_sample_done) begin
                        r_par_bad <= (w_sampled_bit != w_par_exp);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output registers: one-cycle outcome strobes, held word, busy flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
            r_busy       <= (w_next_state != IDLE);
            if (w_frame_done) begin
                if (!r_par_bad && w_sampled_bit) begin
                    r_data_valid <= 1'b1;
                    r_p_data     <= r_shift;
                end else begin
                    r_par_err <= r_par_bad;
                    r_stp_err <= ~w_sampled_bit;
                end
            end
        end
    end

    assign p_data     = r_p_data;
    assign data_valid = r_data_valid;
    assign par_err    = r_par_err;
    assign stp_err    = r_stp_err;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fsm
//  Description : Directed self-checking bench for uart_rx_fsm with a
//                frame-level expectation model and per-cycle comparison.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fsm;

    localparam int DW = 8;
    localparam int P  = 8;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          rx_in   = 1'b1;
    logic          par_en  = 1'b0;
    logic          par_typ = 1'b0;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          busy;

    uart_rx_fsm #(
        .DATA_WIDTH (DW),
        .PRESCALE   (P)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Cycle index: value n between posedge n and posedge n+1
    int   cyc   = 0;
    logic rst_q = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // One expected frame outcome: busy over [s, e), strobes at e
    typedef struct {
        int            s;
        int            e;
        logic [DW-1:0] d;
        bit            ok;
        bit            pe;
        bit            se;
    } ev_t;

    ev_t           evq[$];
    logic [DW-1:0] m_pdata = '0;
    bit            chk_en  = 1'b0;
    int            n_vec   = 0;
    int            n_err   = 0;

    int   n_dv = 0, n_pe = 0, n_se = 0;
    int   dv_cyc = -1, pe_cyc = -1, se_cyc = -1;
    int   busy_rise = -1, busy_fall = -1;
    logic prev_busy = 1'b0;
    int   frame_s = 0;

    int glt_a_bit = -1, glt_a_off = -1, glt_b_bit = -1, glt_b_off = -1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic good_par(input logic [DW-1:0] d, input logic pt);
        return (^d) ^ pt;
    endfunction

    // Per-cycle comparison of every output against the frame model
    always @(negedge clk) begin : cmp
        logic e_dv, e_pe, e_se, e_busy;
        if (chk_en) begin
            e_dv = 1'b0; e_pe = 1'b0; e_se = 1'b0; e_busy = 1'b0;
            if (!rst_q) begin
                evq.delete();
                m_pdata = '0;
            end else if (evq.size() > 0) begin
                if (cyc >= evq[0].s && cyc < evq[0].e) e_busy = 1'b1;
                if (cyc == evq[0].e) begin
                    e_dv = evq[0].ok;
                    e_pe = evq[0].pe;
                    e_se = evq[0].se;
                    if (evq[0].ok) m_pdata = evq[0].d;
                    void'(evq.pop_front());
                end
            end
            check("data_valid", 32'(data_valid), 32'(e_dv));
            check("par_err",    32'(par_err),    32'(e_pe));
            check("stp_err",    32'(stp_err),    32'(e_se));
            check("busy",       32'(busy),       32'(e_busy));
            check("p_data",     32'(p_data),     32'(m_pdata));
            if (data_valid === 1'b1) begin n_dv++; dv_cyc = cyc; end
            if (par_err === 1'b1)    begin n_pe++; pe_cyc = cyc; end
            if (stp_err === 1'b1)    begin n_se++; se_cyc = cyc; end
            if (busy === 1'b1 && !prev_busy) busy_rise = cyc;
            if (busy === 1'b0 && prev_busy)  busy_fall = cyc;
            prev_busy = (busy === 1'b1);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame, P cycles per bit; entered and left on a negedge.
    // rst_bit >= 0 pulses reset at that frame bit and abandons the frame.
    task automatic send_frame(input logic [DW-1:0] d, input bit with_par, input logic pt,
                              input logic par_bit, input logic stop_bit, input int rst_bit);
        int   nb;
        logic val;
        logic lvl;
        ev_t  ev;
        nb      = 2 + DW + (with_par ? 1 : 0);
        ev.s    = cyc + 3;
        ev.e    = ev.s + P * (nb - 1) + P / 2 + 2;
        ev.d    = d;
        ev.pe   = with_par && (par_bit != good_par(d, pt));
        ev.se   = !stop_bit;
        ev.ok   = !ev.pe && !ev.se;
        frame_s = ev.s;
        evq.push_back(ev);
        par_en  = with_par;
        par_typ = pt;
        for (int b = 0; b < nb; b++) begin
            if (b == 0)                        val = 1'b0;
            else if (b <= DW)                  val = d[b-1];
            else if (with_par && b == DW + 1)  val = par_bit;
            else                               val = stop_bit;
            for (int o = 0; o < P; o++) begin
                if (b == rst_bit && o == 2) begin
                    rst   = 1'b0;
                    rx_in = 1'b1;
                    @(negedge clk);
                    rst   = 1'b1;
                    return;
                end
                lvl = val;
                // A bad stop bit is released one cycle early so the line is idle on return to IDLE
                if (b == nb - 1 && !stop_bit && o == P - 1) lvl = 1'b1;
                if ((b == glt_a_bit && o == glt_a_off) || (b == glt_b_bit && o == glt_b_off)) lvl = ~lvl;
                rx_in = lvl;
                if (b == 4 && o == 0) begin
                    par_en  = ~with_par;
                    par_typ = ~pt;
                end
                @(negedge clk);
            end
        end
        rx_in = 1'b1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int dv0, pe0, se0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        idle(6);

        // 1: 0xA5, no parity
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle(20);
        check("t1_busy_rise", 32'(busy_rise), 32'(frame_s));
        check("t1_latency",   32'(dv_cyc - frame_s), 32'd78);
        check("t1_busy_len",  32'(busy_fall - busy_rise), 32'd78);
        check("t1_pdata",     32'(p_data), 32'h0000_00A5);

        // 2: 0x3C even parity, correct then wrong parity bit
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, -1);
        idle(20);
        check("t2a_latency", 32'(dv_cyc - frame_s), 32'd86);
        check("t2a_pdata",   32'(p_data), 32'h0000_003C);
        dv0 = n_dv;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        idle(20);
        check("t2b_latency", 32'(pe_cyc - frame_s), 32'd86);
        check("t2b_no_dv",   32'(n_dv - dv0), 32'd0);
        check("t2b_pdata",   32'(p_data), 32'h0000_003C);

        // 3: 0x5A with stop bit 0
        dv0 = n_dv; pe0 = n_pe;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(20);
        check("t3_latency", 32'(se_cyc - frame_s), 32'd78);
        check("t3_no_dv",   32'(n_dv - dv0), 32'd0);
        check("t3_no_pe",   32'(n_pe - pe0), 32'd0);
        check("t3_pdata",   32'(p_data), 32'h0000_003C);

        // 4: 3-cycle low glitch rejected in START, then 0x81
        dv0 = n_dv; pe0 = n_pe; se0 = n_se;
        begin
            ev_t ev;
            ev.s = cyc + 3; ev.e = ev.s + P / 2 + 2; ev.d = '0;
            ev.ok = 1'b0; ev.pe = 1'b0; ev.se = 1'b0;
            frame_s = ev.s;
            evq.push_back(ev);
        end
        rx_in = 1'b0;
        idle(3);
        rx_in = 1'b1;
        idle(20);
        check("t4_busy_rise", 32'(busy_rise), 32'(frame_s));
        check("t4_busy_len",  32'(busy_fall - busy_rise), 32'd6);
        check("t4_no_strobe", 32'((n_dv - dv0) + (n_pe - pe0) + (n_se - se0)), 32'd0);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle(20);
        check("t4_pdata", 32'(p_data), 32'h0000_0081);

        // 5: back-to-back 0x01, 0xFE with odd parity and sample-point glitches
        dv0 = n_dv; pe0 = n_pe; se0 = n_se;
        glt_a_bit = 3; glt_a_off = 4;
        send_frame(8'h01, 1'b1, 1'b1, good_par(8'h01, 1'b1), 1'b1, -1);
        glt_a_bit = -1; glt_a_off = -1;
        glt_b_bit = 7; glt_b_off = 6;
        send_frame(8'hFE, 1'b1, 1'b1, good_par(8'hFE, 1'b1), 1'b1, -1);
        glt_b_bit = -1; glt_b_off = -1;
        idle(20);
        check("t5_dv_count", 32'(n_dv - dv0), 32'd2);
        check("t5_no_err",   32'((n_pe - pe0) + (n_se - se0)), 32'd0);
        check("t5_pdata",    32'(p_data), 32'h0000_00FE);

        // 6: reset pulse during data bit 3, then 0x7E
        dv0 = n_dv;
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        idle(100);
        check("t6_no_dv", 32'(n_dv - dv0), 32'd0);
        check("t6_pdata_rst", 32'(p_data), 32'h0000_0000);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle(20);
        check("t6_pdata", 32'(p_data), 32'h0000_007E);
        check("t6_dv_count", 32'(n_dv - dv0), 32'd1);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
